// File: rtl/osc_meas_ctrl.sv
// osc_meas_ctrl: runs one gated ring-oscillator measurement per accepted start and reports the edge count.
// Latency: done lands in cycle start+1+SETTLE_CYC+window; for window==0 it lands in cycle start+1.
// Backpressure: none; start is ignored while busy or in DONE and is never queued; abort cancels a run.
// Ports: i_clk / i_rst (synchronous, active-high) clock and reset;
//        i_start, i_abort, i_window: request side (window latched on accepted start);
//        o_osc_en -> oscillator enable, i_osc_in <- free-running oscillator output (async to i_clk);
//        o_busy, o_done, o_valid, o_count, o_overflow, o_stuck: status and result.
// Optional feature: define OSC_STUCK_DET_EN to end a run early when no edge arrives for STUCK_LIMIT cycles.
module osc_meas_ctrl #(
  parameter int WIN_W       = 16,
  parameter int CNT_W       = 16,
  parameter int SETTLE_CYC  = 4,
  parameter int SYNC_STAGES = 2,
  parameter int STUCK_LIMIT = 64
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic             i_abort,
  input  logic [WIN_W-1:0] i_window,
  output logic             o_osc_en,
  input  logic             i_osc_in,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_valid,
  output logic [CNT_W-1:0] o_count,
  output logic             o_overflow,
  output logic             o_stuck
);

  localparam int SET_W = $clog2(SETTLE_CYC + 1);

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_COUNT, S_DONE} state_t;

  state_t                 r_state, w_state_nxt;
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_sync_prev;
  // r_win holds the latched window and then counts it down during COUNT.
  logic [WIN_W-1:0]       r_win, w_win_nxt;
  logic [SET_W-1:0]       r_set, w_set_nxt;
  logic                   r_osc_en, w_osc_en_nxt;
  logic                   r_busy, w_busy_nxt;
  logic                   r_done, w_done_nxt;
  logic                   r_valid, w_valid_nxt;
  logic [CNT_W-1:0]       r_count, w_count_nxt;
  logic                   r_overflow, w_overflow_nxt;
  logic                   r_stuck, w_stuck_nxt;
  logic                   w_edge;
  logic                   w_stuck_hit;

  // Rising edge of the synchronised oscillator; an oscillator faster than two
  // clk periods aliases here and is simply under-counted.
  assign w_edge = r_sync[SYNC_STAGES-1] & ~r_sync_prev;

`ifdef OSC_STUCK_DET_EN
  localparam int IDL_W = $clog2(STUCK_LIMIT + 1);

  logic [IDL_W-1:0] r_idle, w_idle_nxt;

  // Counts edge-free COUNT cycles; held at zero through SETTLE so every run
  // starts COUNT with a fresh budget.
  always_comb begin
    w_idle_nxt  = r_idle;
    w_stuck_hit = 1'b0;
    if (r_state == S_SETTLE) begin
      w_idle_nxt = '0;
    end else if (r_state == S_COUNT) begin
      if (w_edge) begin
        w_idle_nxt = '0;
      end else begin
        w_idle_nxt  = r_idle + 1'b1;
        w_stuck_hit = (r_idle == IDL_W'(STUCK_LIMIT - 1));
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) r_idle <= '0;
    else       r_idle <= w_idle_nxt;
  end
`else
  // Detector compiled out: false for every legal limit.
  assign w_stuck_hit = (STUCK_LIMIT < 0);
`endif

  always_comb begin
    w_state_nxt    = r_state;
    w_win_nxt      = r_win;
    w_set_nxt      = r_set;
    w_osc_en_nxt   = r_osc_en;
    w_busy_nxt     = r_busy;
    w_done_nxt     = 1'b0;
    w_valid_nxt    = r_valid;
    w_count_nxt    = r_count;
    w_overflow_nxt = r_overflow;
    w_stuck_nxt    = r_stuck;

    // Edges seen in any COUNT cycle, including the last one, are counted.
    if ((r_state == S_COUNT) && w_edge) begin
      if (&r_count) w_overflow_nxt = 1'b1;
      else          w_count_nxt    = r_count + 1'b1;
    end

    if (i_abort) begin
      // Abort beats everything, including a simultaneous start in IDLE; the
      // partial count is left visible.
      w_state_nxt  = S_IDLE;
      w_osc_en_nxt = 1'b0;
      w_busy_nxt   = 1'b0;
      w_valid_nxt  = 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (i_start) begin
            w_count_nxt    = '0;
            w_overflow_nxt = 1'b0;
            w_stuck_nxt    = 1'b0;
            if (i_window != '0) begin
              w_win_nxt    = i_window;
              w_set_nxt    = SET_W'(SETTLE_CYC);
              w_valid_nxt  = 1'b0;
              w_osc_en_nxt = 1'b1;
              w_busy_nxt   = 1'b1;
              w_state_nxt  = S_SETTLE;
            end else begin
              // Empty window: report zero straight away, oscillator stays off.
              w_done_nxt  = 1'b1;
              w_valid_nxt = 1'b1;
              w_state_nxt = S_DONE;
            end
          end
        end
        S_SETTLE: begin
          if (r_set == SET_W'(1)) w_state_nxt = S_COUNT;
          else                    w_set_nxt   = r_set - 1'b1;
        end
        S_COUNT: begin
          w_win_nxt = r_win - 1'b1;
          if ((r_win == WIN_W'(1)) || w_stuck_hit) begin
            // osc_en falls on the same edge that enters DONE, so no later
            // edge can reach the counter.
            w_osc_en_nxt = 1'b0;
            w_busy_nxt   = 1'b0;
            w_done_nxt   = 1'b1;
            w_valid_nxt  = 1'b1;
            w_stuck_nxt  = w_stuck_hit;
            w_state_nxt  = S_DONE;
          end
        end
        S_DONE: begin
          w_state_nxt = S_IDLE;
        end
        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_sync      <= '0;
      r_sync_prev <= 1'b0;
      r_win       <= '0;
      r_set       <= '0;
      r_osc_en    <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_valid     <= 1'b0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_stuck     <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_sync      <= {r_sync[SYNC_STAGES-2:0], i_osc_in};
      r_sync_prev <= r_sync[SYNC_STAGES-1];
      r_win       <= w_win_nxt;
      r_set       <= w_set_nxt;
      r_osc_en    <= w_osc_en_nxt;
      r_busy      <= w_busy_nxt;
      r_done      <= w_done_nxt;
      r_valid     <= w_valid_nxt;
      r_count     <= w_count_nxt;
      r_overflow  <= w_overflow_nxt;
      r_stuck     <= w_stuck_nxt;
    end
  end

  assign o_osc_en   = r_osc_en;
  assign o_busy     = r_busy;
  assign o_done     = r_done;
  assign o_valid    = r_valid;
  assign o_count    = r_count;
  assign o_overflow = r_overflow;
  assign o_stuck    = r_stuck;

endmodule

// File: tb/tb_osc_meas_ctrl.sv
// tb_osc_meas_ctrl: directed bench for osc_meas_ctrl with a cycle-level reference model.
// Two instances share stimulus: a 16-bit counter and a 4-bit counter (to reach saturation).
// The bench plays the oscillator itself, gated by the DUT's enable.
module tb_osc_meas_ctrl;

  localparam int S     = 4;
  localparam int SYNC  = 2;
  localparam int LIMIT = 64;
  localparam int MAX_A = 65535;
  localparam int MAX_B = 15;
`ifdef OSC_STUCK_DET_EN
  localparam bit STUCK_ON = 1'b1;
`else
  localparam bit STUCK_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        abort;
  logic [15:0] window;
  logic        osc = 1'b0;

  logic        a_osc_en, a_busy, a_done, a_valid, a_overflow, a_stuck;
  logic [15:0] a_count;
  logic        b_osc_en, b_busy, b_done, b_valid, b_overflow, b_stuck;
  logic [3:0]  b_count;

  int errors = 0;
  int checks = 0;

  // oscillator control, written only by the main sequence
  int half  = 3;
  bit hold0 = 1'b0;

  always #5 clk = ~clk;

  osc_meas_ctrl #(.WIN_W(16), .CNT_W(16), .SETTLE_CYC(S), .SYNC_STAGES(SYNC), .STUCK_LIMIT(LIMIT)) u_a (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_abort(abort), .i_window(window),
    .o_osc_en(a_osc_en), .i_osc_in(osc), .o_busy(a_busy), .o_done(a_done), .o_valid(a_valid),
    .o_count(a_count), .o_overflow(a_overflow), .o_stuck(a_stuck));

  osc_meas_ctrl #(.WIN_W(16), .CNT_W(4), .SETTLE_CYC(S), .SYNC_STAGES(SYNC), .STUCK_LIMIT(LIMIT)) u_b (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_abort(abort), .i_window(window),
    .o_osc_en(b_osc_en), .i_osc_in(osc), .o_busy(b_busy), .o_done(b_done), .o_valid(b_valid),
    .o_count(b_count), .o_overflow(b_overflow), .o_stuck(b_stuck));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Oscillator: toggles every `half` clk cycles while enabled, changes on negedge.
  initial begin
    int ph;
    ph = 0;
    forever begin
      @(negedge clk);
      if (!a_osc_en || hold0) begin
        osc = 1'b0;
        ph  = 0;
      end else begin
        ph++;
        if (ph >= half) begin
          osc = ~osc;
          ph  = 0;
        end
      end
    end
  end

  // ---------------- reference model ----------------
  // A run is tracked by the index of the cycle now beginning (1 = first cycle
  // after acceptance). Cycles 1..S settle, S+1..S+W count, then one result cycle.
  // A rising transition between two clk samples of the oscillator becomes
  // countable SYNC-1 cycles after the later sample.
  bit   m_ready = 1'b0;
  bit   m_run = 1'b0, m_dn = 1'b0;
  int   m_t = 0, m_w = 0, m_edges = 0, m_idle = 0;
  logic [7:0] oh = '0;
  bit   rise_prev = 1'b0, rise_now;
  logic e_en = 1'b0, e_busy = 1'b0, e_done = 1'b0, e_valid = 1'b0, e_stuck = 1'b0;

  initial forever begin
    @(posedge clk);
    oh       = {oh[6:0], osc};
    rise_now = oh[SYNC-1] & ~oh[SYNC];
    if (rst) begin
      m_run = 0; m_dn = 0; m_edges = 0; m_idle = 0; oh = '0; rise_now = 1'b0;
      e_en = 0; e_busy = 0; e_done = 0; e_valid = 0; e_stuck = 0;
      m_ready = 1'b1;
    end else begin
      e_done = 1'b0;
      if (m_run) begin
        if (m_t > S) begin
          if (rise_prev) begin m_edges++; m_idle = 0; end
          else m_idle++;
        end
        if (abort) begin
          m_run = 0; e_en = 0; e_busy = 0; e_valid = 0;
        end else if ((m_t == S + m_w) || (STUCK_ON && m_t > S && m_idle == LIMIT)) begin
          m_run = 0; m_dn = 1; e_done = 1; e_valid = 1; e_en = 0; e_busy = 0;
          e_stuck = STUCK_ON && (m_idle == LIMIT);
        end else begin
          m_t++;
        end
      end else if (m_dn) begin
        m_dn = 0;
        if (abort) e_valid = 0;
      end else if (abort) begin
        e_valid = 0;
      end else if (start) begin
        m_edges = 0; e_stuck = 0;
        if (window != 0) begin
          m_run = 1; m_t = 1; m_w = window; m_idle = 0;
          e_valid = 0; e_en = 1; e_busy = 1;
        end else begin
          m_dn = 1; e_done = 1; e_valid = 1;
        end
      end
    end
    rise_prev = rise_now;
  end

  // Every cycle after the first reset edge: both instances against the model.
  initial forever begin
    @(negedge clk);
    if (m_ready) begin
      chk("a_osc_en",   32'(a_osc_en),   32'(e_en));
      chk("a_busy",     32'(a_busy),     32'(e_busy));
      chk("a_done",     32'(a_done),     32'(e_done));
      chk("a_valid",    32'(a_valid),    32'(e_valid));
      chk("a_count",    32'(a_count),    32'((m_edges > MAX_A) ? MAX_A : m_edges));
      chk("a_overflow", 32'(a_overflow), 32'(m_edges > MAX_A));
      chk("a_stuck",    32'(a_stuck),    32'(e_stuck));
      chk("b_osc_en",   32'(b_osc_en),   32'(e_en));
      chk("b_busy",     32'(b_busy),     32'(e_busy));
      chk("b_done",     32'(b_done),     32'(e_done));
      chk("b_valid",    32'(b_valid),    32'(e_valid));
      chk("b_count",    32'(b_count),    32'((m_edges > MAX_B) ? MAX_B : m_edges));
      chk("b_overflow", 32'(b_overflow), 32'(m_edges > MAX_B));
      chk("b_stuck",    32'(b_stuck),    32'(e_stuck));
    end
  end

  // Start a run and wait (bounded) for done. lat is the cycle index of done
  // counted from the start cycle; poke pulses start again in that busy cycle.
  task automatic run_meas(input int w, input int poke, output int lat, output int en_hi);
    en_hi = 0;
    @(negedge clk); start = 1'b1; window = 16'(w);
    @(negedge clk); start = 1'b0; lat = 1;
    while (!a_done && lat < 3000) begin
      if (a_osc_en) en_hi++;
      start = (lat == poke);
      @(negedge clk); lat++;
    end
    start = 1'b0;
    if (a_osc_en) en_hi++;
    chk("done_seen", 32'(a_done), 32'd1);
  endtask

  initial begin
    int lat, en_hi;
    bit seen;
    rst = 1'b1; start = 1'b0; abort = 1'b0; window = '0;
    repeat (3) @(negedge clk);
    chk("rst_osc_en",   32'(a_osc_en), 0);
    chk("rst_busy",     32'(a_busy), 0);
    chk("rst_done",     32'(a_done), 0);
    chk("rst_valid",    32'(a_valid), 0);
    chk("rst_count",    32'(a_count), 0);
    chk("rst_overflow", 32'(a_overflow), 0);
    chk("rst_stuck",    32'(a_stuck), 0);
    rst = 1'b0;
    @(negedge clk);

    // T1: period 6, window 60 -> done in cycle 1+4+60, 9 or 10 edges
    half = 3;
    run_meas(60, 0, lat, en_hi);
    chk("t1_lat", 32'(lat), 65);
    chk("t1_count_9_or_10", 32'((a_count == 9) || (a_count == 10)), 1);
    chk("t1_overflow", 32'(a_overflow), 0);
    chk("t1_valid", 32'(a_valid), 1);
    @(negedge clk);
    chk("t1_done_pulse_ends", 32'(a_done), 0);
    chk("t1_valid_held", 32'(a_valid), 1);

    // T2: period 4, window 100 -> ~25 edges; the 4-bit copy saturates
    half = 2;
    run_meas(100, 0, lat, en_hi);
    chk("t2_lat", 32'(lat), 105);
    chk("t2_b_count", 32'(b_count), 15);
    chk("t2_b_overflow", 32'(b_overflow), 1);
    chk("t2_a_overflow", 32'(a_overflow), 0);

    // T3: empty window
    run_meas(0, 0, lat, en_hi);
    chk("t3_lat", 32'(lat), 1);
    chk("t3_count", 32'(a_count), 0);
    chk("t3_valid", 32'(a_valid), 1);
    chk("t3_osc_en_never", 32'(en_hi), 0);

    // abort together with start in IDLE: abort wins and clears valid
    @(negedge clk); start = 1'b1; abort = 1'b1; window = 16'd50;
    @(negedge clk); start = 1'b0; abort = 1'b0;
    chk("abort_start_busy", 32'(a_busy), 0);
    chk("abort_start_valid", 32'(a_valid), 0);

    // T4: abort in COUNT cycle 10
    half = 3;
    @(negedge clk); start = 1'b1; window = 16'd200;
    @(negedge clk); start = 1'b0;
    repeat (S + 10 - 1) @(negedge clk);
    abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    chk("t4_osc_en", 32'(a_osc_en), 0);
    chk("t4_busy", 32'(a_busy), 0);
    chk("t4_valid", 32'(a_valid), 0);
    seen = 1'b0;
    repeat (250) begin
      @(negedge clk);
      if (a_done) seen = 1'b1;
    end
    chk("t4_no_done", 32'(seen), 0);
    run_meas(20, 0, lat, en_hi);
    chk("t4_restart_lat", 32'(lat), 25);

    // T5: oscillator dead
    hold0 = 1'b1;
    run_meas(1000, 0, lat, en_hi);
`ifdef OSC_STUCK_DET_EN
    chk("t5_lat", 32'(lat), 1 + S + LIMIT);
    chk("t5_stuck", 32'(a_stuck), 1);
`else
    chk("t5_lat", 32'(lat), 1005);
    chk("t5_stuck", 32'(a_stuck), 0);
`endif
    chk("t5_count", 32'(a_count), 0);
    hold0 = 1'b0;

    // T6: reset mid-COUNT, then starts while busy are ignored
    @(negedge clk); start = 1'b1; window = 16'd200;
    @(negedge clk); start = 1'b0;
    repeat (S + 20 - 1) @(negedge clk);
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    chk("t6_osc_en", 32'(a_osc_en), 0);
    chk("t6_busy", 32'(a_busy), 0);
    chk("t6_valid", 32'(a_valid), 0);
    chk("t6_count", 32'(a_count), 0);
    run_meas(30, 2, lat, en_hi);
    chk("t6_settle_start_ignored", 32'(lat), 35);
    run_meas(30, S + 5, lat, en_hi);
    chk("t6_count_start_ignored", 32'(lat), 35);
    chk("t6_osc_en_cycles", 32'(en_hi), S + 30);
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule
